// File: rtl/rr_hold_scheduler.sv
// rr_hold_scheduler: round-robin owner of one shared resource. A grant is held
// until the owner strobes done, drops its request, or the hold limit expires;
// one idle cycle always separates consecutive grants.
module rr_hold_scheduler #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    // A zero MAX_HOLD disables the limit; keep a 1-bit counter so widths stay legal.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HW-1:0] HOLD_SAT  = '1;
    localparam logic [IW-1:0] LAST_ID   = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   gnt_id_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            timeout_nxt;
    logic [IW-1:0]   pick;
    logic            pick_ok;
    logic            rel_done, rel_req, rel_hold, release_now;

    // Round-robin scan: first set request starting at ptr, wrapping modulo N.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!pick_ok && req[idx]) begin
                pick    = IW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        rel_done    = done[gnt_id];
        rel_req     = !req[gnt_id];
        rel_hold    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        release_now = rel_done || rel_req || rel_hold;
    end

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (en && pick_ok) begin
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    gnt_id_nxt    = pick;
                    hold_nxt      = '0;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + HW'(1);
                end
                if (release_now) begin
                    gnt_nxt     = '0;
                    ptr_nxt     = (gnt_id == LAST_ID) ? '0 : gnt_id + IW'(1);
                    state_nxt   = IDLE;
                    // Timeout is reported only when the limit alone forced the release.
                    timeout_nxt = rel_hold && !rel_done && !rel_req;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset revokes any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_hold_scheduler.sv
// tb_rr_hold_scheduler: directed-step bench for rr_hold_scheduler (N=4, MAX_HOLD=16).
module tb_rr_hold_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    rr_hold_scheduler #(.N(4), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks gnt, gnt_id, gnt_valid and timeout together.
    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic t);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        logic [3:0] g;
        rst  = 1'b1;
        en   = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        #1;
        chk_all("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // 1: all request, done after 3 cycles -> 0,1,2,3,0 with one idle cycle between.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            tick();
            chk_all("rr_c1", g, 2'(k % 4), 1'b1, 1'b0);
            tick();
            chk("rr_c2.gnt", 32'(gnt), 32'(g));
            tick();
            chk("rr_c3.gnt", 32'(gnt), 32'(g));
            done = g;
            tick();
            done = 4'b0000;
            chk_all("rr_gap", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
        end
        req = 4'b0000;
        tick();
        chk_all("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2: lone requester 2, no done -> 16 cycles, timeout gap, re-grant.
        req = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("hold.gnt", 32'(gnt), 32'h4);
            chk("hold.timeout", 32'(timeout), 32'h0);
        end
        tick();
        chk_all("hold_expire", 4'b0000, 2'd2, 1'b0, 1'b1);
        tick();
        chk_all("hold_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // 3: owner 2 drops req on cycle 5 while req[3] is high.
        req = 4'b1100;
        tick();
        tick();
        tick();
        tick();
        chk("drop_c5.gnt", 32'(gnt), 32'h4);
        req = 4'b1000;
        tick();
        chk_all("drop_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick();
        chk_all("drop_next", 4'b1000, 2'd3, 1'b1, 1'b0);

        // 4: non-owner done ignored; done together with the limit releases without timeout.
        req  = 4'b0011;
        done = 4'b1000;
        tick();
        done = 4'b0000;
        chk_all("done3_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick();
        chk_all("own0_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        chk_all("nonowner_done", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("own0_hold.gnt", 32'(gnt), 32'h1);
        end
        done = 4'b0001;
        tick();
        done = 4'b0000;
        chk_all("done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("after_limit", 4'b0010, 2'd1, 1'b1, 1'b0);

        // 5: en=0 during a grant lets it finish but blocks the next one.
        en = 1'b0;
        tick();
        chk("en0_c2.gnt", 32'(gnt), 32'h2);
        tick();
        chk("en0_c3.gnt", 32'(gnt), 32'h2);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        chk_all("en0_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("en0_frozen", 4'b0000, 2'd1, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        chk_all("en1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // 6: reset mid-grant clears outputs asynchronously and ptr returns to 0.
        tick();
        chk("pre_rst.gnt", 32'(gnt), 32'h1);
        #2;
        rst = 1'b1;
        req = 4'b1010;
        #1;
        chk_all("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_all("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
